// File: rtl/mem_mgmt_pkg.sv
// rtl/mem_mgmt_pkg.sv - shared widths and types for the memory-management blocks
package mem_mgmt_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int STATS_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0]  mem_addr_t;
    typedef logic [STATS_WIDTH-1:0] stats_t;

    // Which register currently feeds the allocation output
    typedef enum logic {
        OR_SRC_HOST = 1'b0,
        OR_SRC_POOL = 1'b1
    } or_src_e;

endpackage

// File: rtl/addr_sync_fifo.sv
// rtl/addr_sync_fifo.sv - local address pool, synchronous FIFO with registered read
module addr_sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Occupancy decides legality; pop only sees words committed on an earlier edge
    assign do_push = push & ~flush & (count != FULL);
    assign do_pop  = pop  & ~flush & (count != '0);

    // Storage array carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered read word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_addr_recycler.sv
// rtl/mem_addr_recycler.sv - recycles reclaimed value-store addresses ahead of host refills
module mem_addr_recycler
    import mem_mgmt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int HIGH_WM    = 12
) (
    input  logic                  ACLK,
    input  logic                  rst,
    input  logic                  flushReq,
    input  logic [DATA_WIDTH-1:0] host_free_data,
    input  logic                  host_free_valid,
    output logic                  host_free_ready,
    output logic [DATA_WIDTH-1:0] mcd_alloc_data,
    output logic                  mcd_alloc_valid,
    input  logic                  mcd_alloc_ready,
    input  logic [DATA_WIDTH-1:0] mcd_del_data,
    input  logic                  mcd_del_valid,
    output logic                  mcd_del_ready,
    output logic [DATA_WIDTH-1:0] host_del_data,
    output logic                  host_del_valid,
    input  logic                  host_del_ready,
    output stats_t                stats_recycled,
    output stats_t                stats_returned
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HWM = CW'(HIGH_WM);

    logic                  out_en;
    logic                  active;
    logic                  route_local;
    logic                  pool_push;
    logic                  pool_pop;
    logic                  pool_nonempty;
    logic                  load;
    logic [CW-1:0]         pool_count;
    logic [DATA_WIDTH-1:0] pool_dout;
    logic [DATA_WIDTH-1:0] host_word;
    or_src_e               or_src;

    // Handshake outputs stay quiet during reset, for one cycle after it, and during flush
    assign active        = out_en & ~rst & ~flushReq;
    assign pool_nonempty = (pool_count != '0);

    // Deletions fill the pool up to the watermark, the rest pass straight to the host
    assign route_local    = active & (pool_count < HWM);
    assign mcd_del_ready  = route_local | (active & host_del_ready);
    assign host_del_valid = active & mcd_del_valid & ~route_local;
    assign host_del_data  = mcd_del_data;
    assign pool_push      = mcd_del_valid & route_local;

    // Refill the output register whenever it is empty or being consumed; pool wins over host
    assign load            = active & (~mcd_alloc_valid | mcd_alloc_ready);
    assign pool_pop        = load & pool_nonempty;
    assign host_free_ready = load & ~pool_nonempty & host_free_valid;

    // Pool words land in the FIFO's own read register, so only the host word needs capturing
    assign mcd_alloc_data = (or_src == OR_SRC_POOL) ? pool_dout : host_word;

    addr_sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pool (
        .clk   (ACLK),
        .rst   (rst),
        .flush (flushReq),
        .push  (pool_push),
        .pop   (pool_pop),
        .din   (mcd_del_data),
        .dout  (pool_dout),
        .count (pool_count)
    );

    // Output-enable that holds handshakes off on the first cycle out of reset
    always_ff @(posedge ACLK) begin
        if (rst) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    // Allocation output register: valid and source select
    always_ff @(posedge ACLK) begin
        if (rst) begin
            mcd_alloc_valid <= 1'b0;
            host_word       <= '0;
            or_src          <= OR_SRC_HOST;
        end else if (flushReq) begin
            mcd_alloc_valid <= 1'b0;
        end else if (pool_pop) begin
            mcd_alloc_valid <= 1'b1;
            or_src          <= OR_SRC_POOL;
        end else if (host_free_ready) begin
            mcd_alloc_valid <= 1'b1;
            or_src          <= OR_SRC_HOST;
            host_word       <= host_free_data;
        end else if (mcd_alloc_ready) begin
            mcd_alloc_valid <= 1'b0;
        end
    end

    // Recycled/returned counters; free-running wrap, cleared only by reset
    always_ff @(posedge ACLK) begin
        if (rst) begin
            stats_recycled <= '0;
            stats_returned <= '0;
        end else begin
            if (pool_push) begin
                stats_recycled <= stats_recycled + STATS_WIDTH'(1);
            end
            if (host_del_valid && host_del_ready) begin
                stats_returned <= stats_returned + STATS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_addr_recycler.sv
// tb/tb_mem_addr_recycler.sv - self-checking bench for mem_addr_recycler
module tb_mem_addr_recycler;

    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int HIGH_WM = 12;

    logic          ACLK;
    logic          rst;
    logic          flushReq;
    logic [DW-1:0] host_free_data;
    logic          host_free_valid;
    logic          host_free_ready;
    logic [DW-1:0] mcd_alloc_data;
    logic          mcd_alloc_valid;
    logic          mcd_alloc_ready;
    logic [DW-1:0] mcd_del_data;
    logic          mcd_del_valid;
    logic          mcd_del_ready;
    logic [DW-1:0] host_del_data;
    logic          host_del_valid;
    logic          host_del_ready;
    logic [31:0]   stats_recycled;
    logic [31:0]   stats_returned;

    mem_addr_recycler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HIGH_WM(HIGH_WM)) dut (
        .ACLK            (ACLK),
        .rst             (rst),
        .flushReq        (flushReq),
        .host_free_data  (host_free_data),
        .host_free_valid (host_free_valid),
        .host_free_ready (host_free_ready),
        .mcd_alloc_data  (mcd_alloc_data),
        .mcd_alloc_valid (mcd_alloc_valid),
        .mcd_alloc_ready (mcd_alloc_ready),
        .mcd_del_data    (mcd_del_data),
        .mcd_del_valid   (mcd_del_valid),
        .mcd_del_ready   (mcd_del_ready),
        .host_del_data   (host_del_data),
        .host_del_valid  (host_del_valid),
        .host_del_ready  (host_del_ready),
        .stats_recycled  (stats_recycled),
        .stats_returned  (stats_returned)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          flush_strobes = 0;
    logic [31:0] host_q[$];
    logic [31:0] del_q[$];
    logic [31:0] alloc_log[$];
    logic [31:0] hdel_log[$];
    int          alloc_cyc[$];
    int          hfr_cyc[$];
    bit          hfr_seen = 0;
    bit          del_acc_seen = 0;

    // Reference model: pool as a queue, output register as valid+word, plain counters
    logic [31:0] pool_q[$];
    bit          m_known = 0;
    bit          m_first = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rec = '0;
    logic [31:0] m_ret = '0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        host_free_valid = (host_q.size() != 0);
        host_free_data  = host_free_valid ? host_q[0] : '0;
        mcd_del_valid   = (del_q.size() != 0);
        mcd_del_data    = mcd_del_valid ? del_q[0] : '0;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        if (hfr_seen && host_q.size() != 0) void'(host_q.pop_front());
        if (del_acc_seen && del_q.size() != 0) void'(del_q.pop_front());
        drive();
    endtask

    task automatic wait_allocs(input int n, input int budget);
        int k;
        k = 0;
        while (alloc_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("alloc_wait", 32'(alloc_log.size() >= n), 32'd1);
    endtask

    task automatic wait_del_drain(input int budget);
        int k;
        k = 0;
        while (del_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk("del_drain_wait", 32'(del_q.size()), 32'd0);
    endtask

    // Per-cycle compare against the model, then advance the model by this cycle's inputs
    initial begin
        bit active, e_local, e_dready, e_hdv, can_load, e_hfr;
        forever begin
            @(negedge ACLK);
            cyc++;
            hfr_seen     = host_free_ready;
            del_acc_seen = mcd_del_valid && mcd_del_ready;
            if (host_free_ready) hfr_cyc.push_back(cyc);
            if (mcd_alloc_valid && mcd_alloc_ready) begin
                alloc_log.push_back(mcd_alloc_data);
                alloc_cyc.push_back(cyc);
            end
            if (host_del_valid && host_del_ready) hdel_log.push_back(host_del_data);
            if (flushReq && (host_free_ready || host_del_valid || mcd_del_ready)) flush_strobes++;

            active   = m_known && !rst && !m_first && !flushReq;
            e_local  = active && (pool_q.size() < HIGH_WM);
            e_dready = active && (e_local || host_del_ready);
            e_hdv    = active && mcd_del_valid && !e_local;
            can_load = active && (!m_valid || mcd_alloc_ready);
            e_hfr    = can_load && (pool_q.size() == 0) && host_free_valid;

            if (m_known) begin
                chk("alloc_valid", 32'(mcd_alloc_valid), 32'(m_valid));
                if (m_valid) chk("alloc_data", mcd_alloc_data, m_data);
                chk("host_free_ready", 32'(host_free_ready), 32'(e_hfr));
                chk("mcd_del_ready", 32'(mcd_del_ready), 32'(e_dready));
                chk("host_del_valid", 32'(host_del_valid), 32'(e_hdv));
                if (e_hdv) chk("host_del_data", host_del_data, mcd_del_data);
                chk("stats_recycled", stats_recycled, m_rec);
                chk("stats_returned", stats_returned, m_ret);
                chk("pool_count", 32'(dut.pool_count), 32'(pool_q.size()));
            end

            if (rst) begin
                pool_q.delete();
                m_valid = 0;
                m_data  = '0;
                m_rec   = '0;
                m_ret   = '0;
                m_first = 1;
                m_known = 1;
            end else if (m_known) begin
                if (flushReq) begin
                    pool_q.delete();
                    m_valid = 0;
                end else if (active) begin
                    if (can_load && pool_q.size() != 0) begin
                        m_data  = pool_q.pop_front();
                        m_valid = 1;
                    end else if (e_hfr) begin
                        m_data  = host_free_data;
                        m_valid = 1;
                    end else if (m_valid && mcd_alloc_ready) begin
                        m_valid = 0;
                    end
                    if (mcd_del_valid && e_local) begin
                        pool_q.push_back(mcd_del_data);
                        m_rec = m_rec + 32'd1;
                    end
                    if (e_hdv && host_del_ready) m_ret = m_ret + 32'd1;
                end
                m_first = 0;
            end
        end
    end

    initial begin
        int base;
        logic [31:0] rec_snap, ret_snap;

        rst = 1; flushReq = 0; mcd_alloc_ready = 0; host_del_ready = 1;
        drive();
        repeat (3) step();

        // Reset state and host-only allocation
        rst = 0;
        host_q.push_back(32'h100);
        host_q.push_back(32'h200);
        mcd_alloc_ready = 1;
        drive();
        #1;
        chk("rst_alloc_valid", 32'(mcd_alloc_valid), 32'd0);
        chk("rst_alloc_data", mcd_alloc_data, 32'd0);
        chk("rst_hfr_first_cycle", 32'(host_free_ready), 32'd0);
        chk("rst_del_ready", 32'(mcd_del_ready), 32'd0);
        chk("rst_stats_recycled", stats_recycled, 32'd0);
        chk("rst_stats_returned", stats_returned, 32'd0);
        wait_allocs(2, 10);
        chk("host_alloc_0", alloc_log[0], 32'h100);
        chk("host_alloc_1", alloc_log[1], 32'h200);
        chk("host_alloc_back_to_back", 32'(alloc_cyc[1] - alloc_cyc[0]), 32'd1);
        chk("host_alloc_latency", 32'(alloc_cyc[0] - hfr_cyc[0]), 32'd1);
        step();
        chk("host_pop_strobes", 32'(hfr_cyc.size()), 32'd2);
        mcd_alloc_ready = 0;
        drive();

        // Local recycling takes priority over the host
        del_q.push_back(32'hA0);
        del_q.push_back(32'hA4);
        drive();
        repeat (4) step();
        host_q.push_back(32'h300);
        drive();
        repeat (2) step();
        mcd_alloc_ready = 1;
        drive();
        wait_allocs(5, 20);
        chk("recycle_alloc_0", alloc_log[2], 32'hA0);
        chk("recycle_alloc_1", alloc_log[3], 32'hA4);
        chk("recycle_alloc_2", alloc_log[4], 32'h300);
        chk("recycle_stats", stats_recycled, 32'd2);
        mcd_alloc_ready = 0;
        drive();

        // Watermark overflow with the output register parked
        host_q.push_back(32'h500);
        drive();
        repeat (2) step();
        for (int i = 0; i < 14; i++) del_q.push_back(32'hD00 + 32'(4 * i));
        drive();
        wait_del_drain(40);
        chk("wm_host_del_count", 32'(hdel_log.size()), 32'd2);
        chk("wm_host_del_13", hdel_log[0], 32'hD30);
        chk("wm_host_del_14", hdel_log[1], 32'hD34);
        chk("wm_stats_returned", stats_returned, 32'd2);
        chk("wm_stats_recycled", stats_recycled, 32'd14);
        chk("wm_pool_count", 32'(dut.pool_count), 32'd12);

        // Host back-pressure holds the deletion
        host_del_ready = 0;
        del_q.push_back(32'hBEE0);
        drive();
        repeat (3) step();
        chk("bp_del_ready", 32'(mcd_del_ready), 32'd0);
        chk("bp_del_held", 32'(del_q.size()), 32'd1);
        host_del_ready = 1;
        drive();
        #1;
        chk("bp_release_valid", 32'(host_del_valid), 32'd1);
        chk("bp_release_ready", 32'(mcd_del_ready), 32'd1);
        step();
        chk("bp_forwarded", hdel_log[2], 32'hBEE0);
        chk("bp_stats_returned", stats_returned, 32'd3);

        // Flush with 5 in the pool and a parked output word
        mcd_alloc_ready = 1;
        drive();
        repeat (7) step();
        mcd_alloc_ready = 0;
        drive();
        chk("pre_flush_pool", 32'(dut.pool_count), 32'd5);
        chk("pre_flush_valid", 32'(mcd_alloc_valid), 32'd1);
        rec_snap = stats_recycled;
        ret_snap = stats_returned;
        flushReq = 1;
        host_q.push_back(32'h600);
        del_q.push_back(32'hE0);
        drive();
        repeat (3) step();
        flushReq = 0;
        drive();
        #1;
        chk("flush_valid", 32'(mcd_alloc_valid), 32'd0);
        chk("flush_pool", 32'(dut.pool_count), 32'd0);
        chk("flush_strobes", 32'(flush_strobes), 32'd0);
        chk("flush_stats_recycled", stats_recycled, 32'd14);
        chk("flush_stats_returned", stats_returned, 32'd3);
        chk("flush_stats_stable", 32'(stats_recycled == rec_snap && stats_returned == ret_snap), 32'd1);
        base = alloc_log.size();
        mcd_alloc_ready = 1;
        drive();
        wait_allocs(base + 2, 10);
        chk("post_flush_host", alloc_log[base], 32'h600);
        chk("post_flush_pool", alloc_log[base + 1], 32'hE0);
        mcd_alloc_ready = 0;
        drive();

        // Simultaneous push and pop with one word pooled
        del_q.push_back(32'hC0);
        drive();
        repeat (3) step();
        del_q.push_back(32'hC4);
        drive();
        repeat (2) step();
        chk("pp_pool_before", 32'(dut.pool_count), 32'd1);
        chk("pp_parked_word", mcd_alloc_data, 32'hC0);
        del_q.push_back(32'hC8);
        mcd_alloc_ready = 1;
        drive();
        step();
        mcd_alloc_ready = 0;
        drive();
        chk("pp_pool_after", 32'(dut.pool_count), 32'd1);
        chk("pp_next_word", mcd_alloc_data, 32'hC4);

        // Recycled counter wrap
        force dut.stats_recycled = 32'hFFFF_FFFF;
        m_rec = 32'hFFFF_FFFF;
        #1;
        release dut.stats_recycled;
        del_q.push_back(32'hCC);
        drive();
        #1;
        chk("wrap_preload", stats_recycled, 32'hFFFF_FFFF);
        step();
        chk("wrap_result", stats_recycled, 32'd0);

        // Reset mid-transfer discards pool and output word
        rst = 1;
        drive();
        step();
        rst = 0;
        host_q.delete();
        del_q.delete();
        host_q.push_back(32'h700);
        drive();
        #1;
        chk("rst2_valid", 32'(mcd_alloc_valid), 32'd0);
        chk("rst2_data", mcd_alloc_data, 32'd0);
        chk("rst2_pool", 32'(dut.pool_count), 32'd0);
        chk("rst2_hfr", 32'(host_free_ready), 32'd0);
        chk("rst2_stats_returned", stats_returned, 32'd0);
        base = alloc_log.size();
        mcd_alloc_ready = 1;
        drive();
        wait_allocs(base + 1, 10);
        chk("rst2_host_alloc", alloc_log[base], 32'h700);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_addr_recycler.md
# mem_addr_recycler

Sits between the PCIe memory-allocation bridge and the memcached pipeline on the memcached (ACLK) side. Keeps a small local pool of value-store addresses reclaimed by memcached and hands them straight back out on the next DRAM allocation request, so host software only refills the pool when it runs dry. Addresses it cannot hold are forwarded to the host through the bridge's deletion FIFO. It also counts locally recycled and host-returned addresses for the stats registers.

## Interface
- DATA_WIDTH, 32: address word width.
- DEPTH, 16: local pool depth. Power of two, ≥4.
- HIGH_WM, 12: local-routing threshold, 1 ≤ HIGH_WM ≤ DEPTH.

- ACLK  in  1  clock; everything is single clock domain.
- rst  in  1  reset, synchronous, active-high.
- flushReq  in  1  memcached flush in progress. Level signal.
- host_free_data  in  DATA_WIDTH  head of bridge DRAM free FIFO (first-word-fall-through).
- host_free_valid  in  1  bridge FIFO not empty.
- host_free_ready  out  1  pop strobe to bridge FIFO (rd_en).
- mcd_alloc_data  out  DATA_WIDTH  allocated address to memcached.
- mcd_alloc_valid  out  1  allocated address is valid.
- mcd_alloc_ready  in  1  memcached accepts the allocated address.
- mcd_del_data  in  DATA_WIDTH  address reclaimed by memcached.
- mcd_del_valid  in  1  reclaimed address is valid.
- mcd_del_ready  out  1  this block accepts the reclaimed address.
- host_del_data  out  DATA_WIDTH  reclaimed address forwarded to the bridge deletion FIFO.
- host_del_valid  out  1  write strobe to the bridge deletion FIFO (wr_en).
- host_del_ready  in  1  bridge deletion FIFO not full.
- stats_recycled  out  32  count of addresses pushed into the local pool.
- stats_returned  out  32  count of addresses forwarded to the host.

## Operation
- **Local pool:** synchronous FIFO of DEPTH entries.
  - Occupancy count is $clog2(DEPTH)+1 bits wide.
  - A simultaneous push and pop leaves the count unchanged.
  - There is no bypass: a word pushed in cycle N can be popped at the earliest in cycle N+1.
- **Deletion routing** (combinational, evaluated every cycle):
  - route_local = (count < HIGH_WM) & ~flushReq.
  - mcd_del_ready = route_local | (host_del_ready & ~flushReq).
  - host_del_valid = mcd_del_valid & ~route_local & ~flushReq; host_del_data = mcd_del_data.
  - Local push = mcd_del_valid & route_local.
- **Allocation output register (OR):**
  - Load condition: `load = ~flushReq & (~mcd_alloc_valid | mcd_alloc_ready)`.
  - If load and the pool is non-empty: pop the pool into OR.
  - Otherwise, if load and host_free_valid: host_free_ready=1 and host_free_data is captured into OR.
  - Otherwise, if the OR was consumed, mcd_alloc_valid drops to 0.
  - host_free_ready is never asserted while host_free_valid=0.
  - The local pool always has priority over the host.
- **Flush** (while flushReq=1):
  - The pool is emptied: count←0, pointers←0.
  - The OR is invalidated: mcd_alloc_valid←0.
  - Reclaimed addresses are neither accepted nor forwarded: mcd_del_ready=0.
  - host_free_ready=0; the bridge resets its own FIFOs during a flush.
  - Normal operation resumes on the cycle after flushReq falls.
- **Stats:**
  - stats_recycled increments on every local push.
  - stats_returned increments on every cycle with host_del_valid & host_del_ready.
  - Both counters wrap modulo 2^32.
  - Both are cleared only by rst, not by flushReq.

## Timing
- All outputs below are 0 during rst and on the first cycle after rst: mcd_alloc_valid, host_free_ready, host_del_valid, mcd_del_ready, and both stats counters. mcd_alloc_data resets to 0.
- **Allocation latency:** 1 cycle from source pop to mcd_alloc_valid.
  - Sustained throughput is 1 address per cycle, from either source.
- **Deletion path:** 0-cycle combinational pass-through to the host, so forwarding has no added latency.
- **mcd_alloc handshake:** valid/data hold stable until ready.
  - Valid never drops without a handshake, except on flushReq or rst.
- **Boundaries:**
  - Pool full: cannot happen, because HIGH_WM ≤ DEPTH blocks the push.
  - Pool empty and host empty: mcd_alloc_valid stays 0 after any current word is consumed.
  - rst has priority over flushReq.
  - rst mid-transfer discards OR and pool contents.

## Structure
- Shared package `mem_mgmt_pkg` holds:
  - ADDR_WIDTH=32.
  - STATS_WIDTH=32.
  - the address typedef `mem_addr_t`.
- One sub-module, `addr_sync_fifo` (DEPTH, DATA_WIDTH), with ports:
  - push, pop, din, dout (registered read), count, flush.
- Routing, the output register and the stats counters live in the top module.
- Estimated size is about 200 lines.

## Test plan
- **Host-only allocation:** after reset, with the pool empty, host FIFO holds 0x100, 0x200 and mcd_alloc_ready=1.
  - Required: 0x100 then 0x200 on consecutive cycles, each 1 cycle after its pop.
  - Required: host_free_ready strobed exactly twice.
- **Local recycling priority:** push deletions 0xA0, 0xA4 while host FIFO holds 0x300.
  - Required: next allocations are 0xA0, 0xA4, then 0x300.
  - Required: stats_recycled=2.
- **Watermark overflow** (HIGH_WM=12, no allocations): 14 deletions.
  - Required: the first 12 go to the pool; the 13th and 14th appear on host_del.
  - Required: stats_returned=2.
- **Host back-pressure:** pool at HIGH_WM and host_del_ready=0.
  - Required: mcd_del_ready=0 and the deletion is held.
  - Required: it forwards in the cycle host_del_ready rises.
- **Flush mid-operation:** pool holds 5, the OR is valid and not accepted, then flushReq is pulsed for 3 cycles.
  - Required: mcd_alloc_valid=0, pool count=0, no host_free_ready or host_del_valid during the flush.
  - Required: stats unchanged.
- **Simultaneous push/pop and stats wrap:**
  - Deletion and allocation in the same cycle with 1 word in the pool: required count stays 1.
  - Preload stats_recycled=0xFFFFFFFF via force, then one push: required count reads 0.
